// File: rtl/adc_spi_sampler.sv
// Serial ADC front end: runs 16-clock SPI frames while sample_enable is high and
// presents the low 12 bits of each frame as ADC_DATA with a one-cycle strobe.
module adc_spi_sampler #(
   parameter int CLK_DIV      = 4,
   parameter int QUIET_CYCLES = 8
) (
   input  logic        PCLK,
   input  logic        PRESET,
   input  logic        sample_enable,
   input  logic        adc_sdo,
   output logic        adc_cs_n,
   output logic        adc_sclk,
   output logic [11:0] ADC_DATA,
   output logic        data_valid,
   output logic        busy,
   output logic [15:0] sample_count
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CS_SETUP = 2'd1,
      SHIFT    = 2'd2,
      QUIET    = 2'd3
   } state_t;

   localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
   localparam logic [15:0] QUIET_LAST = 16'(QUIET_CYCLES - 1);

   state_t      state;
   logic [15:0] cnt;
   logic [3:0]  bit_cnt;
   logic [15:0] shreg;

   // Frame sequencer; every output is a register updated here.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state        <= IDLE;
         cnt          <= 16'd0;
         bit_cnt      <= 4'd0;
         shreg        <= 16'd0;
         adc_cs_n     <= 1'b1;
         adc_sclk     <= 1'b1;
         ADC_DATA     <= 12'h000;
         data_valid   <= 1'b0;
         busy         <= 1'b0;
         sample_count <= 16'd0;
      end else begin
         data_valid <= 1'b0;
         case (state)
            IDLE: begin
               adc_cs_n <= 1'b1;
               adc_sclk <= 1'b1;
               if (sample_enable) begin
                  state    <= CS_SETUP;
                  adc_cs_n <= 1'b0;
                  busy     <= 1'b1;
                  cnt      <= 16'd0;
                  bit_cnt  <= 4'd0;
                  shreg    <= 16'd0;
               end else begin
                  busy <= 1'b0;
               end
            end
            CS_SETUP: begin
               if (cnt == DIV_LAST) begin
                  state    <= SHIFT;
                  adc_sclk <= 1'b0;
                  cnt      <= 16'd0;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            SHIFT: begin
               if (cnt != DIV_LAST) begin
                  cnt <= cnt + 16'd1;
               end else if (!adc_sclk) begin
                  cnt      <= 16'd0;
                  adc_sclk <= 1'b1;
                  shreg    <= {shreg[14:0], adc_sdo};
                  bit_cnt  <= bit_cnt + 4'd1;
               end else if (bit_cnt == 4'd0) begin
                  // bit_cnt wraps to zero only after the 16th sample edge
                  cnt          <= 16'd0;
                  state        <= QUIET;
                  adc_cs_n     <= 1'b1;
                  ADC_DATA     <= shreg[11:0];
                  data_valid   <= 1'b1;
                  sample_count <= sample_count + 16'd1;
               end else begin
                  cnt      <= 16'd0;
                  adc_sclk <= 1'b0;
               end
            end
            QUIET: begin
               adc_cs_n <= 1'b1;
               adc_sclk <= 1'b1;
               if (cnt == QUIET_LAST) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  cnt   <= 16'd0;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            default: begin
               state    <= IDLE;
               adc_cs_n <= 1'b1;
               adc_sclk <= 1'b1;
               busy     <= 1'b0;
               cnt      <= 16'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Directed bench for adc_spi_sampler: a behavioural ADC drives adc_sdo from a
// 16-bit word per frame; a default instance and a CLK_DIV=1/QUIET_CYCLES=1 instance.
module tb_adc_spi_sampler;

   logic        PCLK = 1'b0;
   logic        PRESET = 1'b1;
   logic        sample_enable = 1'b0;
   logic        adc_sdo = 1'b0;
   logic        adc_cs_n, adc_sclk, data_valid, busy;
   logic [11:0] ADC_DATA;
   logic [15:0] sample_count;

   logic        en2 = 1'b0;
   logic        sdo2 = 1'b0;
   logic        cs2_n, sclk2, dv2, busy2;
   logic [11:0] data2;
   logic [15:0] count2;

   int passed = 0;
   int total  = 0;

   adc_spi_sampler dut (
      .PCLK(PCLK), .PRESET(PRESET), .sample_enable(sample_enable), .adc_sdo(adc_sdo),
      .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .ADC_DATA(ADC_DATA),
      .data_valid(data_valid), .busy(busy), .sample_count(sample_count)
   );

   adc_spi_sampler #(.CLK_DIV(1), .QUIET_CYCLES(1)) dut2 (
      .PCLK(PCLK), .PRESET(PRESET), .sample_enable(en2), .adc_sdo(sdo2),
      .adc_cs_n(cs2_n), .adc_sclk(sclk2), .ADC_DATA(data2),
      .data_valid(dv2), .busy(busy2), .sample_count(count2)
   );

   always #5 PCLK = ~PCLK;

   // ADC model: latches next_word when CS falls, presents bit 15 first after
   // the first SCLK fall and the next lower bit after each following fall.
   logic [15:0] next_word = 16'h0000, cur_word = 16'h0000;
   int          falls = 0;
   logic        prev_cs = 1'b1, prev_sclk = 1'b1;
   always @(posedge PCLK) begin
      #1;
      if (prev_cs && !adc_cs_n) begin
         cur_word = next_word;
         falls = 0;
      end else if (prev_sclk && !adc_sclk && !adc_cs_n && falls < 16) begin
         falls = falls + 1;
         adc_sdo = cur_word[16 - falls];
      end
      prev_cs = adc_cs_n;
      prev_sclk = adc_sclk;
   end

   logic [15:0] next_word2 = 16'h0000, cur_word2 = 16'h0000;
   int          falls2 = 0;
   logic        prev_cs2 = 1'b1, prev_sclk2 = 1'b1;
   always @(posedge PCLK) begin
      #1;
      if (prev_cs2 && !cs2_n) begin
         cur_word2 = next_word2;
         falls2 = 0;
      end else if (prev_sclk2 && !sclk2 && !cs2_n && falls2 < 16) begin
         falls2 = falls2 + 1;
         sdo2 = cur_word2[16 - falls2];
      end
      prev_cs2 = cs2_n;
      prev_sclk2 = sclk2;
   end

   // Strobe-width monitor for both instances.
   int   dv_double = 0;
   logic prev_dv = 1'b0, prev_dv2 = 1'b0;
   always @(posedge PCLK) begin
      #1;
      if ((data_valid && prev_dv) || (dv2 && prev_dv2)) dv_double = dv_double + 1;
      prev_dv = data_valid;
      prev_dv2 = dv2;
   end

   typedef struct {
      logic [15:0] word;
      logic [11:0] exp_data;
   } vec_t;
   vec_t vecs [4];

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total = total + 1;
      if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      else passed = passed + 1;
   endtask

   // Ticks until data_valid of the default instance is seen (bounded).
   task automatic wait_valid(output int t);
      t = 0;
      do begin
         tick();
         t = t + 1;
      end while (!data_valid && t < 1000);
      chk("valid_seen", {31'd0, data_valid}, 32'd1);
   endtask

   task automatic wait_idle();
      int t = 0;
      while (busy && t < 1000) begin
         tick();
         t = t + 1;
      end
      chk("return_idle", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int t, hc, lows, t2;
      vecs[0] = '{16'h0FFF, 12'hFFF};
      vecs[1] = '{16'h0000, 12'h000};
      vecs[2] = '{16'h0801, 12'h801};
      vecs[3] = '{16'hF5A3, 12'h5A3};

      // Reset values after three cycles of PRESET.
      repeat (3) tick();
      chk("rst_cs_n", {31'd0, adc_cs_n}, 32'd1);
      chk("rst_sclk", {31'd0, adc_sclk}, 32'd1);
      chk("rst_data", {20'd0, ADC_DATA}, 32'h0);
      chk("rst_valid", {31'd0, data_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_count", {16'd0, sample_count}, 32'd0);
      PRESET = 1'b0;
      lows = 0;
      repeat (10) begin
         tick();
         if (!adc_cs_n || !adc_sclk || busy) lows = lows + 1;
      end
      chk("idle_quiet_lines", lows, 32'd0);

      // Single frame from a one-cycle enable pulse.
      next_word = 16'h0A5C;
      sample_enable = 1'b1;
      tick();
      sample_enable = 1'b0;
      chk("cs_low_cycle0", {31'd0, adc_cs_n}, 32'd0);
      wait_valid(t);
      chk("valid_latency", t, 32'd132);
      chk("single_data", {20'd0, ADC_DATA}, 32'hA5C);
      chk("single_count", {16'd0, sample_count}, 32'd1);
      tick();
      chk("valid_one_cycle", {31'd0, data_valid}, 32'd0);
      repeat (6) tick();
      chk("busy_at_139", {31'd0, busy}, 32'd1);
      tick();
      chk("busy_at_140", {31'd0, busy}, 32'd0);
      lows = 0;
      repeat (20) begin
         tick();
         if (!adc_cs_n) lows = lows + 1;
      end
      chk("single_no_refire", lows, 32'd0);

      // Back-to-back frames with the enable held high, driven from the table.
      next_word = vecs[0].word;
      sample_enable = 1'b1;
      hc = 0;
      for (int i = 0; i < 4; i++) begin
         wait_valid(t);
         if (i > 0) chk("period_141", hc + t, 32'd141);
         chk("cont_data", {20'd0, ADC_DATA}, {20'd0, vecs[i].exp_data});
         if (i < 3) begin
            next_word = vecs[i + 1].word;
            hc = 1;
            while (adc_cs_n && hc < 100) begin
               tick();
               if (adc_cs_n) hc = hc + 1;
            end
            // QUIET_CYCLES plus the single IDLE cycle before the next CS fall
            if (i == 0) chk("cs_high_gap", hc, 32'd9);
         end else begin
            sample_enable = 1'b0;
         end
      end
      chk("cont_count", {16'd0, sample_count}, 32'd5);
      wait_idle();

      // Enable dropped at the 5th sample edge; leading nibble discarded.
      tick();
      next_word = 16'hF123;
      sample_enable = 1'b1;
      tick();
      for (int k = 0; k < 40; k++) tick();
      sample_enable = 1'b0;
      wait_valid(t);
      chk("disable_data", {20'd0, ADC_DATA}, 32'h123);
      chk("disable_count", {16'd0, sample_count}, 32'd6);
      lows = 0;
      repeat (300) begin
         tick();
         if (!adc_cs_n) lows = lows + 1;
      end
      chk("disable_no_second", lows, 32'd0);

      // PRESET at the 9th sample edge aborts the frame.
      next_word = 16'h0FAB;
      sample_enable = 1'b1;
      tick();
      for (int k = 0; k < 72; k++) tick();
      chk("pre_abort_cs", {31'd0, adc_cs_n}, 32'd0);
      PRESET = 1'b1;
      sample_enable = 1'b0;
      tick();
      chk("abort_cs_n", {31'd0, adc_cs_n}, 32'd1);
      chk("abort_sclk", {31'd0, adc_sclk}, 32'd1);
      chk("abort_data", {20'd0, ADC_DATA}, 32'h0);
      chk("abort_count", {16'd0, sample_count}, 32'd0);
      chk("abort_valid", {31'd0, data_valid}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      PRESET = 1'b0;
      tick();
      next_word = 16'h0ABC;
      sample_enable = 1'b1;
      tick();
      sample_enable = 1'b0;
      wait_valid(t);
      chk("after_abort_latency", t, 32'd132);
      chk("after_abort_data", {20'd0, ADC_DATA}, 32'hABC);
      chk("after_abort_count", {16'd0, sample_count}, 32'd1);
      wait_idle();

      // Counter wrap from 16'hFFFF.
      force dut.sample_count = 16'hFFFF;
      tick();
      release dut.sample_count;
      next_word = 16'h0321;
      sample_enable = 1'b1;
      tick();
      sample_enable = 1'b0;
      wait_valid(t);
      chk("wrap_count", {16'd0, sample_count}, 32'd0);
      chk("wrap_data", {20'd0, ADC_DATA}, 32'h321);
      wait_idle();

      // Minimum-parameter instance: 35-cycle period.
      next_word2 = 16'h0A5C;
      en2 = 1'b1;
      tick();
      t2 = 0;
      while (!dv2 && t2 < 200) begin
         tick();
         t2 = t2 + 1;
      end
      chk("p1_latency", t2, 32'd33);
      chk("p1_data0", {20'd0, data2}, 32'hA5C);
      next_word2 = 16'hE801;
      t2 = 0;
      do begin
         tick();
         t2 = t2 + 1;
      end while (!dv2 && t2 < 200);
      en2 = 1'b0;
      chk("p1_period", t2, 32'd35);
      chk("p1_data1", {20'd0, data2}, 32'h801);
      chk("p1_count", {16'd0, count2}, 32'd2);
      repeat (10) tick();
      chk("p1_idle", {31'd0, busy2}, 32'd0);

      chk("valid_never_double", dv_double, 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
